msrv32_irq_agg: RTL and testbench

Parametrised interrupt aggregator that drives the core's three interrupt inputs (ms_riscv32_mp_eirq_in, ms_riscv32_mp_tirq_in, ms_riscv32_mp_sirq_in). It replaces the single pass-through external IRQ line with NUM_SRC synchronised sources, each individually set to level or rising-edge mode. It adds enable masking, a pending/claim/complete handshake, a software-interrupt bit and a machine timer with compare. Registers are accessed through a simple single-cycle register port owned by the data-side bus decoder.

---
 rtl/msrv32_irq_pkg.sv | 29 ++
 rtl/msrv32_sync_cell.sv | 25 ++
 rtl/msrv32_irq_agg.sv | 172 +++++++++++++++++
 tb/tb_msrv32_irq_agg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_irq_pkg.sv
// Shared constants and helpers for the msrv32 interrupt aggregator.
package msrv32_irq_pkg;

    // Claim IDs run 0..31 (0 = nothing eligible), so five bits cover up to 31 sources.
    localparam int IRQ_ID_W  = 5;
    localparam int IRQ_REG_W = 3;

    // Register word indices on the register port.
    localparam logic [IRQ_REG_W-1:0] IRQ_REG_ENABLE   = 3'd0;
    localparam logic [IRQ_REG_W-1:0] IRQ_REG_MODE     = 3'd1;
    localparam logic [IRQ_REG_W-1:0] IRQ_REG_PENDING  = 3'd2;
    localparam logic [IRQ_REG_W-1:0] IRQ_REG_CLAIM    = 3'd3;
    localparam logic [IRQ_REG_W-1:0] IRQ_REG_SWI      = 3'd4;
    localparam logic [IRQ_REG_W-1:0] IRQ_REG_MTIME    = 3'd5;
    localparam logic [IRQ_REG_W-1:0] IRQ_REG_MTIMECMP = 3'd6;

    // Lowest set bit wins; returns its index+1, or 0 when the vector is empty.
    function automatic logic [IRQ_ID_W-1:0] irq_find_first(input logic [30:0] vec);
        logic [IRQ_ID_W-1:0] id;
        id = '0;
        for (int i = 30; i >= 0; i--) begin
            if (vec[i]) begin
                id = IRQ_ID_W'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/msrv32_sync_cell.sv
// Single-bit multi-flop synchroniser for an asynchronous interrupt line.
module msrv32_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw input through the flop chain.
    // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/msrv32_irq_agg.sv
// Interrupt aggregator: synchronised level/edge sources with enable, pending,
// claim/complete, a software interrupt bit and a machine timer with compare.
module msrv32_irq_agg
    import msrv32_irq_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 32
) (
    input  logic               ms_riscv32_mp_clk_in,
    input  logic               ms_riscv32_mp_rst_in,
    input  logic [NUM_SRC-1:0] irq_src_in,
    input  logic               reg_req_in,
    input  logic               reg_wr_in,
    input  logic [2:0]         reg_addr_in,
    input  logic [31:0]        reg_wdata_in,
    output logic [31:0]        reg_rdata_out,
    output logic               reg_ack_out,
    output logic               ms_riscv32_mp_eirq_out,
    output logic               ms_riscv32_mp_tirq_out,
    output logic               ms_riscv32_mp_sirq_out
);

    // Source synchronisers.
    logic [NUM_SRC-1:0] sync_w;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        msrv32_sync_cell #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (ms_riscv32_mp_clk_in),
            .rst_ni(ms_riscv32_mp_rst_in),
            .d_i   (irq_src_in[g]),
            .q_o   (sync_w[g])
        );
    end

    // Architectural state.
    logic [NUM_SRC-1:0] enable_q,    enable_d;
    logic [NUM_SRC-1:0] mode_q,      mode_d;
    logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] sync_prev_q;
    logic               swi_q,       swi_d;
    logic [TIMER_W-1:0] mtime_q,     mtime_d;
    logic [TIMER_W-1:0] mtimecmp_q,  mtimecmp_d;

    // Register port and output flops.
    logic [31:0]        rdata_q,     rdata_d;
    logic               ack_q;
    logic               eirq_q;
    logic               tirq_q;
    logic               sirq_q;

    // Derived combinational signals.
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic [IRQ_ID_W-1:0] claim_id;
    logic               rd_en;
    logic               wr_en;
    logic               claim_fire;
    logic [NUM_SRC-1:0] claim_set;
    logic [NUM_SRC-1:0] complete_clr;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [31:0]        rd_word;

    assign rise     = sync_w & ~sync_prev_q;
    assign pending  = (mode_q & edge_pend_q) | (~mode_q & sync_w);
    assign eligible = pending & enable_q & ~in_service_q;
    assign claim_id = irq_find_first(31'(eligible));

    assign rd_en      = reg_req_in & ~reg_wr_in;
    assign wr_en      = reg_req_in &  reg_wr_in;
    assign claim_fire = rd_en && (reg_addr_in == IRQ_REG_CLAIM) && (claim_id != '0);

    // Per-source claim set, complete clear and write-1-to-clear masks.
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        claim_set    = '0;
        complete_clr = '0;
        w1c_clr      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_set[i]    = claim_fire && (claim_id == IRQ_ID_W'(i + 1));
            complete_clr[i] = wr_en && (reg_addr_in == IRQ_REG_CLAIM)
                              && (reg_wdata_in == 32'(i + 1)) && in_service_q[i];
        end
        if (wr_en && (reg_addr_in == IRQ_REG_PENDING)) begin
            w1c_clr = reg_wdata_in[NUM_SRC-1:0] & mode_q;
        end
    end

    // Read mux; unmapped indices and unused bits read as zero.
    always_comb begin
        rd_word = '0;
        case (reg_addr_in)
            IRQ_REG_ENABLE:   rd_word = 32'(enable_q);
            IRQ_REG_MODE:     rd_word = 32'(mode_q);
            IRQ_REG_PENDING:  rd_word = 32'(pending);
            IRQ_REG_CLAIM:    rd_word = 32'(claim_id);
            IRQ_REG_SWI:      rd_word = {31'b0, swi_q};
            IRQ_REG_MTIME:    rd_word = 32'(mtime_q);
            IRQ_REG_MTIMECMP: rd_word = 32'(mtimecmp_q);
            default:          rd_word = '0;
        endcase
    end

    // Next-state for configuration, pending, in-service, timer and read data.
    always_comb begin
        enable_d     = enable_q;
        mode_d       = mode_q;
        swi_d        = swi_q;
        mtimecmp_d   = mtimecmp_q;
        mtime_d      = mtime_q + TIMER_W'(1);
        rdata_d      = rd_en ? rd_word : '0;

        // A fresh edge in the same cycle as a clear keeps the source pending.
        edge_pend_d  = mode_q & ((edge_pend_q & ~(w1c_clr | claim_set)) | rise);
        in_service_d = (in_service_q & ~complete_clr) | claim_set;

        if (wr_en) begin
            case (reg_addr_in)
                IRQ_REG_ENABLE:   enable_d   = reg_wdata_in[NUM_SRC-1:0];
                IRQ_REG_MODE:     mode_d     = reg_wdata_in[NUM_SRC-1:0];
                IRQ_REG_SWI:      swi_d      = reg_wdata_in[0];
                IRQ_REG_MTIME:    mtime_d    = reg_wdata_in[TIMER_W-1:0];
                IRQ_REG_MTIMECMP: mtimecmp_d = reg_wdata_in[TIMER_W-1:0];
                default:          ;
            endcase
        end
    end

    // State, register-port and output flops.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            enable_q     <= '0;
            mode_q       <= '0;
            edge_pend_q  <= '0;
            in_service_q <= '0;
            sync_prev_q  <= '0;
            swi_q        <= 1'b0;
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            rdata_q      <= '0;
            ack_q        <= 1'b0;
            eirq_q       <= 1'b0;
            tirq_q       <= 1'b0;
            sirq_q       <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            edge_pend_q  <= edge_pend_d;
            in_service_q <= in_service_d;
            sync_prev_q  <= sync_w;
            swi_q        <= swi_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            rdata_q      <= rdata_d;
            ack_q        <= reg_req_in;
            eirq_q       <= |eligible;
            tirq_q       <= (mtime_q >= mtimecmp_q);
            sirq_q       <= swi_q;
        end
    end

    assign reg_rdata_out          = rdata_q;
    assign reg_ack_out            = ack_q;
    assign ms_riscv32_mp_eirq_out = eirq_q;
    assign ms_riscv32_mp_tirq_out = tirq_q;
    assign ms_riscv32_mp_sirq_out = sirq_q;

endmodule

// File: tb/tb_msrv32_irq_agg.sv
// Directed bench for msrv32_irq_agg with hand-computed expectations.
module tb_msrv32_irq_agg;
    import msrv32_irq_pkg::*;

    localparam int NUM_SRC = 8;

    logic               clk;
    logic               rst_n;
    logic [NUM_SRC-1:0] src;
    logic               req;
    logic               wr;
    logic [2:0]         addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ack;
    logic               eirq;
    logic               tirq;
    logic               sirq;
    logic [31:0]        rd;

    int tests_run    = 0;
    int tests_failed = 0;

    msrv32_irq_agg #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(2),
        .TIMER_W    (32)
    ) dut (
        .ms_riscv32_mp_clk_in  (clk),
        .ms_riscv32_mp_rst_in  (rst_n),
        .irq_src_in            (src),
        .reg_req_in            (req),
        .reg_wr_in             (wr),
        .reg_addr_in           (addr),
        .reg_wdata_in          (wdata),
        .reg_rdata_out         (rdata),
        .reg_ack_out           (ack),
        .ms_riscv32_mp_eirq_out(eirq),
        .ms_riscv32_mp_tirq_out(tirq),
        .ms_riscv32_mp_sirq_out(sirq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the ack must be visible.
    task automatic reg_access(input logic w, input logic [2:0] a, input logic [31:0] d,
                              output logic [31:0] r);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        wr  = 1'b0;
        @(negedge clk);
        check("ack", 32'(ack), 32'd1);
        r = rdata;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        reg_access(1'b1, a, d, dummy);
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] r);
        reg_access(1'b0, a, 32'd0, r);
    endtask

    initial begin
        rst_n = 1'b1;
        src   = '1;
        req   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state with all sources high.
        check("rst_eirq",  32'(eirq),  32'd0);
        check("rst_tirq",  32'(tirq),  32'd0);
        check("rst_sirq",  32'(sirq),  32'd0);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_rdata", rdata,      32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("eirq_disabled", 32'(eirq), 32'd0);
        check("tirq_idle",     32'(tirq), 32'd0);
        reg_read(IRQ_REG_MTIMECMP, rd);
        check("mtimecmp_rst", rd, 32'hFFFF_FFFF);
        reg_read(IRQ_REG_ENABLE, rd);
        check("enable_rst", rd, 32'd0);
        reg_read(IRQ_REG_MODE, rd);
        check("mode_rst", rd, 32'd0);

        // Configure: src[2] edge mode, src[0] level mode, both enabled.
        src = '0;
        repeat (4) @(negedge clk);
        reg_write(IRQ_REG_MODE,   32'h04);
        reg_write(IRQ_REG_ENABLE, 32'h05);

        // src[0] level high and a one-cycle pulse on src[2].
        src = 8'h05;
        @(negedge clk);
        src = 8'h01;
        @(negedge clk);
        check("eirq_lvl_early", 32'(eirq), 32'd0);
        @(negedge clk);
        check("eirq_lvl_lat", 32'(eirq), 32'd1);
        repeat (2) @(negedge clk);
        reg_read(IRQ_REG_PENDING, rd);
        check("pending_both", rd, 32'h05);

        // Claim sequence: lowest index first, then empty.
        reg_read(IRQ_REG_CLAIM, rd);
        check("claim_1", rd, 32'd1);
        reg_read(IRQ_REG_CLAIM, rd);
        check("claim_3", rd, 32'd3);
        check("eirq_before_drop", 32'(eirq), 32'd1);
        reg_read(IRQ_REG_CLAIM, rd);
        check("claim_none", rd, 32'd0);
        check("eirq_dropped", 32'(eirq), 32'd0);
        reg_read(IRQ_REG_PENDING, rd);
        check("pending_after_claim", rd, 32'h01);

        // Complete with an ID that is not in service is ignored.
        reg_write(IRQ_REG_CLAIM, 32'd5);
        reg_read(IRQ_REG_CLAIM, rd);
        check("claim_after_bad_cpl", rd, 32'd0);
        check("eirq_after_bad_cpl", 32'(eirq), 32'd0);

        // Completing src[0] while it is still high re-raises eirq one cycle later.
        reg_write(IRQ_REG_CLAIM, 32'd1);
        check("eirq_cpl_same", 32'(eirq), 32'd0);
        @(negedge clk);
        check("eirq_cpl_next", 32'(eirq), 32'd1);
        reg_read(IRQ_REG_CLAIM, rd);
        check("reclaim_1", rd, 32'd1);
        reg_write(IRQ_REG_CLAIM, 32'd3);

        // Edge-mode latency: only src[2] can become eligible.
        src = 8'h05;
        @(negedge clk);
        src = 8'h01;
        @(negedge clk);
        @(negedge clk);
        check("eirq_edge_early", 32'(eirq), 32'd0);
        @(negedge clk);
        check("eirq_edge_lat", 32'(eirq), 32'd1);

        // Second edge on src[2] lands in the same cycle as its claim.
        src = 8'h05;
        @(negedge clk);
        src = 8'h01;
        @(negedge clk);
        reg_read(IRQ_REG_CLAIM, rd);
        check("claim_same_edge", rd, 32'd3);
        reg_read(IRQ_REG_PENDING, rd);
        check("pending_set_wins", rd, 32'h05);

        // Timer compare: tirq rises five cycles after the MTIME write ack.
        reg_write(IRQ_REG_MTIMECMP, 32'h10);
        reg_write(IRQ_REG_MTIME,    32'h0C);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("tirq_cyc%0d", k), 32'(tirq), (k == 5) ? 32'd1 : 32'd0);
        end

        // Timer wrap.
        reg_write(IRQ_REG_MTIMECMP, 32'hFFFF_FFFF);
        reg_write(IRQ_REG_MTIME,    32'hFFFF_FFFE);
        @(negedge clk);
        check("tirq_wrap_fe", 32'(tirq), 32'd0);
        @(negedge clk);
        check("tirq_wrap_ff", 32'(tirq), 32'd1);
        @(negedge clk);
        check("tirq_wrap_0", 32'(tirq), 32'd0);
        reg_read(IRQ_REG_MTIME, rd);
        check("mtime_wrapped", rd, 32'd1);

        // Software interrupt.
        reg_write(IRQ_REG_SWI, 32'd1);
        @(negedge clk);
        check("sirq_set", 32'(sirq), 32'd1);
        reg_read(IRQ_REG_SWI, rd);
        check("swi_rd", rd, 32'd1);

        // Unmapped index and unused enable bits.
        reg_write(3'd7, 32'hDEAD_BEEF);
        reg_read(3'd7, rd);
        check("unmapped_rd", rd, 32'd0);
        reg_write(IRQ_REG_ENABLE, 32'hFFFF_FFFF);
        reg_read(IRQ_REG_ENABLE, rd);
        check("enable_width", rd, 32'h0000_00FF);

        // Reset in the middle of a request: no ack, everything cleared.
        req  = 1'b1;
        wr   = 1'b0;
        addr = IRQ_REG_ENABLE;
        #2 rst_n = 1'b0;
        #1 req = 1'b0;
        @(negedge clk);
        check("midrst_ack",   32'(ack),  32'd0);
        check("midrst_eirq",  32'(eirq), 32'd0);
        check("midrst_tirq",  32'(tirq), 32'd0);
        check("midrst_sirq",  32'(sirq), 32'd0);
        check("midrst_rdata", rdata,     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ack", 32'(ack), 32'd0);
        reg_read(IRQ_REG_ENABLE, rd);
        check("postrst_enable", rd, 32'd0);
        reg_read(IRQ_REG_MTIMECMP, rd);
        check("postrst_mtimecmp", rd, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
